// File: rtl/statem_decoder.sv
// Input-recovery monitor for the 8-state, 2-input statem FSM: reconstructs the input
// symbol behind each observed state transition and flags ambiguous or illegal steps.
module statem_decoder #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       saida_in,
   output logic [1:0]       a_out,
   output logic [3:0]       cand,
   output logic             valid,
   output logic             ambig,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt
);

   typedef logic [2:0] state_t;

   // Next-state ROM row for one source state, packed as {a=3, a=2, a=1, a=0}.
   function automatic logic [11:0] rom_row(input state_t p);
      logic [11:0] row;
      case (p)
         3'd0:    row = {3'd5, 3'd2, 3'd2, 3'd1};
         3'd1:    row = {3'd6, 3'd3, 3'd3, 3'd2};
         3'd2:    row = {3'd3, 3'd7, 3'd4, 3'd0};
         3'd3:    row = {3'd5, 3'd2, 3'd2, 3'd2};
         3'd4:    row = {3'd3, 3'd7, 3'd3, 3'd0};
         3'd5:    row = {3'd6, 3'd3, 3'd4, 3'd1};
         3'd6:    row = {3'd3, 3'd3, 3'd2, 3'd0};
         default: row = {3'd5, 3'd1, 3'd4, 3'd0};
      endcase
      return row;
   endfunction

   state_t      prev;
   logic [11:0] row;
   logic [3:0]  cand_c;
   logic [1:0]  a_c;
   logic        ambig_c;
   logic        err_c;

   // NOTE: every signal driven here gets a value before any branch, so no latch can be inferred.
   always_comb begin
      cand_c = '0;
      a_c    = 2'd0;
      row    = rom_row(prev);
      for (int k = 0; k < 4; k++) begin
         cand_c[k] = (row[3*k +: 3] == saida_in);
      end
      casez (cand_c)
         4'b???1: a_c = 2'd0;
         4'b??10: a_c = 2'd1;
         4'b?100: a_c = 2'd2;
         4'b1000: a_c = 2'd3;
         default: a_c = 2'd0;
      endcase
      // Clearing the lowest set bit leaves something only when two or more bits are set.
      ambig_c = ((cand_c & (cand_c - 4'd1)) != 4'd0);
      err_c   = (cand_c == 4'd0);
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev    <= 3'd0;
         a_out   <= 2'd0;
         cand    <= 4'd0;
         valid   <= 1'b0;
         ambig   <= 1'b0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else if (en) begin
         // Resynchronise on the observed state even after an illegal step.
         prev  <= saida_in;
         a_out <= a_c;
         cand  <= cand_c;
         valid <= 1'b1;
         ambig <= ambig_c;
         err   <= err_c;
         if (err_c && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end else begin
         valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_statem_decoder.sv
// Scoreboard bench for statem_decoder: a table model predicts each decode at drive time,
// and the prediction is popped and compared when the DUT raises valid.
module tb_statem_decoder;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             en = 1'b0;
   logic [2:0]       saida_in = 3'd0;
   logic [1:0]       a_out;
   logic [3:0]       cand;
   logic             valid;
   logic             ambig;
   logic             err;
   logic [CNT_W-1:0] err_cnt;

   statem_decoder #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .en(en), .saida_in(saida_in),
      .a_out(a_out), .cand(cand), .valid(valid), .ambig(ambig),
      .err(err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]       a;
      logic [3:0]       cand;
      logic             ambig;
      logic             err;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   logic [2:0]       tbl [8][4] = '{
      '{3'd1, 3'd2, 3'd2, 3'd5}, '{3'd2, 3'd3, 3'd3, 3'd6},
      '{3'd0, 3'd4, 3'd7, 3'd3}, '{3'd2, 3'd2, 3'd2, 3'd5},
      '{3'd0, 3'd3, 3'd7, 3'd3}, '{3'd1, 3'd4, 3'd3, 3'd6},
      '{3'd0, 3'd2, 3'd3, 3'd3}, '{3'd0, 3'd4, 3'd1, 3'd5}};
   logic [2:0]       m_prev = 3'd0;
   logic [CNT_W-1:0] m_cnt = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Predict the decode of prev->s from the table and push it.
   task automatic model_push(input logic [2:0] s);
      exp_t x;
      int   n = 0;
      x.cand = '0;
      x.a    = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (tbl[m_prev][k] == s) begin
            x.cand[k] = 1'b1;
            x.a       = 2'(k);
            n++;
         end
      end
      x.ambig = (n >= 2);
      x.err   = (n == 0);
      if (x.err && m_cnt != 4'hF) m_cnt = m_cnt + 1'b1;
      x.cnt  = m_cnt;
      m_prev = s;
      sb.push_back(x);
   endtask

   task automatic step(input logic e, input logic [2:0] s);
      exp_t x;
      @(negedge clk);
      en = e;
      saida_in = s;
      if (e) model_push(s);
      @(posedge clk);
      #1;
      check("valid", valid, e);
      if (valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            x = sb.pop_front();
            check("a_out", a_out, x.a);
            check("cand", cand, x.cand);
            check("ambig", ambig, x.ambig);
            check("err", err, x.err);
            check("err_cnt", err_cnt, x.cnt);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      en = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("rst_outputs", {a_out, cand, valid, ambig, err, err_cnt}, 0);
      sb.delete();
      m_prev = 3'd0;
      m_cnt  = '0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Known legal routes from q0 used to park prev at each state.
   logic [2:0] path [8][2] = '{
      '{3'd0, 3'd0}, '{3'd1, 3'd0}, '{3'd2, 3'd0}, '{3'd1, 3'd3},
      '{3'd2, 3'd4}, '{3'd5, 3'd0}, '{3'd1, 3'd6}, '{3'd2, 3'd7}};
   int path_len [8] = '{0, 1, 1, 2, 2, 1, 2, 2};

   initial begin
      logic [2:0] mat_s [9] = '{3'd2, 3'd4, 3'd7, 3'd1, 3'd3, 3'd2, 3'd0, 3'd5, 3'd6};
      logic [1:0] mat_a [9] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3, 2'd3};
      logic       mat_m [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [2:0] nx;
      logic [3:0] amb_mask;

      #12;
      check("reset_state", {a_out, cand, valid, ambig, err, err_cnt}, 0);
      @(negedge clk);
      reset = 1'b1;

      // Matriculation sequence
      for (int i = 0; i < 9; i++) begin
         step(1'b1, mat_s[i]);
         check($sformatf("mat_a%0d", i), a_out, mat_a[i]);
         check($sformatf("mat_ambig%0d", i), ambig, mat_m[i]);
         check($sformatf("mat_err%0d", i), err, 0);
      end
      check("mat_err_cnt", err_cnt, 0);

      // Illegal transition then resync from q7
      do_reset();
      step(1'b1, 3'd7);
      check("ill_err", err, 1);
      check("ill_cand", cand, 4'b0000);
      check("ill_cnt", err_cnt, 1);
      step(1'b1, 3'd0);
      check("resync_err", err, 0);
      check("resync_unique", ambig, 0);
      check("resync_a", a_out, 0);

      // Saturation of the error counter
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 3'd7);
         check("sat_err", err, 1);
      end
      check("sat_cnt", err_cnt, 15);

      // Enable gating: prev must survive changing input while en=0
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 3'(i + 3));
      step(1'b1, 3'd1);
      check("gate_a", a_out, 0);
      check("gate_unique", {ambig, err}, 0);

      // Async reset mid-run between edges
      do_reset();
      step(1'b1, 3'd2);
      step(1'b1, 3'd4);
      step(1'b1, 3'd0);
      step(1'b1, 3'd1);
      do_reset();
      step(1'b1, 3'd5);
      check("post_rst_a", a_out, 3);

      // Full-table sweep
      for (int p = 0; p < 8; p++) begin
         for (int a = 0; a < 4; a++) begin
            do_reset();
            for (int j = 0; j < path_len[p]; j++) step(1'b1, path[p][j]);
            nx = tbl[p][a];
            step(1'b1, nx);
            check($sformatf("sweep_bit_p%0d_a%0d", p, a), cand[a], 1);
            amb_mask = 4'b0000;
            if (p == 0 && nx == 3'd2) amb_mask = 4'b0110;
            if (p == 1 && nx == 3'd3) amb_mask = 4'b0110;
            if (p == 3 && nx == 3'd2) amb_mask = 4'b0111;
            if (p == 4 && nx == 3'd3) amb_mask = 4'b1010;
            if (p == 6 && nx == 3'd3) amb_mask = 4'b1100;
            if (amb_mask != 4'b0000) check($sformatf("sweep_mask_p%0d_a%0d", p, a), cand, amb_mask);
            else check($sformatf("sweep_onehot_p%0d_a%0d", p, a), cand, 4'b0001 << a);
         end
      end

      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/statem_decoder.md
# statem_decoder

Input-recovery decoder for the 8-state, 2-input `statem` FSM. It observes the FSM's 3-bit state output and reconstructs the 2-bit input symbol that caused each transition. It flags ambiguous transitions, where several inputs reach the same state, and illegal ones, where no input does. It sits on the output side of any `statem` instance (case, gate or memory variant), used as a checker/monitor on the same clock.

## Interface
Parameters:
- `CNT_W`, 4: width of the saturating error counter.

Ports:
- `clk`  in  1  rising-edge clock; one clock, shared with the observed FSM.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample strobe; `saida_in` is consumed on a rising `clk` edge only when `en`=1.
- `saida_in`  in  3  observed FSM state (q0..q7 = 0..7).
- `a_out`  out  2  recovered input symbol: lowest candidate.
- `cand`  out  4  candidate mask; bit k set when input k explains the transition.
- `valid`  out  1  one-cycle pulse: `a_out`/`cand`/`ambig`/`err` updated.
- `ambig`  out  1  more than one candidate.
- `err`  out  1  no candidate: illegal transition.
- `err_cnt`  out  CNT_W  saturating count of illegal transitions since reset.

## Operation
- Internal register `prev[2:0]` holds the last accepted state. Reset value is 0 (q0), matching the FSM reset state.
- Transition table, listing next state for a=0,1,2,3. It is hard-coded as a case ROM and must not be computed from gates:
  - q0: 1,2,2,5
  - q1: 2,3,3,6
  - q2: 0,4,7,3
  - q3: 2,2,2,5
  - q4: 0,3,7,3
  - q5: 1,4,3,6
  - q6: 0,2,3,3
  - q7: 0,4,1,5
- On an edge with `en`=1:
  - `cand[k]` = (table[prev][k] == `saida_in`) for k=0..3.
  - `a_out` = index of the lowest set bit of `cand`, or 0 if `cand`=0.
  - `ambig` = popcount(`cand`) ≥ 2.
  - `err` = (`cand` == 0).
  - `valid` = 1.
  - `prev` <= `saida_in` unconditionally. After an error the decoder resynchronises on the observed state.
  - `err_cnt` increments when `err` is set, saturating at 2^CNT_W−1 with no wrap.
- On an edge with `en`=0: `valid` <= 0. `prev`, `a_out`, `cand`, `ambig`, `err` and `err_cnt` hold.
- `ambig` and `err` are mutually exclusive. `valid`=1 with both clear means a unique decode.
- Ambiguous pairs, each given as (prev→next: mask):
  - q0→2: 0110
  - q1→3: 0110
  - q3→2: 0111
  - q4→3: 1010
  - q6→3: 1100
- Reset mid-operation, `reset` low at any time: immediately sets `prev`=0 and all outputs to 0, independent of `clk`. The first `en` sample after reset release decodes from q0.

## Timing
- All outputs are registered. Reset values: `a_out`=0, `cand`=0, `valid`=0, `ambig`=0, `err`=0, `err_cnt`=0.
- Latency: the FSM state visible at edge N, sampled with `en`=1, produces decode outputs valid after edge N, readable before edge N+1. The decode refers to the transition prev→`saida_in`.
- Throughput: one decode per clock when `en` is held high. Back-to-back samples need no gap.
- The decoder samples `saida_in` in the same cycle the FSM presents it. Connecting the FSM output directly with `en`=1 every cycle after reset release decodes every FSM step.
- `reset` deassertion is treated as synchronous to `clk` by the environment. No internal synchroniser.

## Test plan
- Matriculation sequence: drive the FSM with a = 1,1,2,2,1,2,0,3,3 from reset, `en`=1. `saida_in` = 2,4,7,1,3,2,0,5,6. Required `a_out` = 1,1,2,2,1,0,0,3,3. `ambig` = 1,0,0,0,1,1,0,0,0. `err` all 0. `err_cnt`=0.
- Illegal transition: after reset, present `saida_in`=7. Required: `err`=1, `cand`=0000, `a_out`=0, `err_cnt`=1. Then present 0 (from q7, a=0). Required: `a_out`=0, `err`=0, unique.
- Saturation with `CNT_W`=4: alternate `saida_in` 7,7,… (q7→7 is illegal) for 20 samples. Required: `err_cnt` stops at 15, with `err`=1 on every sample.
- Enable gating: hold `en`=0 for 5 cycles while `saida_in` changes. Required: `valid`=0 and `prev` unchanged. Resuming with `saida_in`=1 from q0 gives `a_out`=0, unique.
- Async reset mid-run: assert `reset`=0 between clock edges after 4 decodes. Required: all outputs go to 0 before the next edge. After release, sample 5 gives `a_out`=3 (q0→5).
- Full-table sweep: for every prev∈0..7 and a∈0..3, force prev via a legal path, then present table[prev][a]. Required: `cand` bit a set, and `cand` matches the mask listed in Operation.
